// File: rtl/ysyx_25040129_mem_arbiter_pkg.sv
// ysyx_25040129_mem_arbiter_pkg: shared FSM/owner encodings and default widths for the memory arbiter
package ysyx_25040129_mem_arbiter_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;
endpackage

// File: rtl/ysyx_25040129_arb_sel.sv
// ysyx_25040129_arb_sel: two-master grant select; round-robin when YSYX_25040129_ARB_RR_EN is defined, else LSU fixed priority
module ysyx_25040129_arb_sel
    import ysyx_25040129_mem_arbiter_pkg::*;
(
    input  logic ifu_valid,
    input  logic lsu_valid,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);
`ifdef YSYX_25040129_ARB_RR_EN
    // on a tie the master that did not win last time gets the grant
    always_comb begin
        grant_valid = ifu_valid | lsu_valid;
        grant       = (ifu_valid && lsu_valid) ? ~last_grant : (lsu_valid ? OWN_LSU : OWN_IFU);
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    // LSU always wins a tie
    always_comb begin
        grant_valid = ifu_valid | lsu_valid;
        grant       = lsu_valid ? OWN_LSU : OWN_IFU;
    end
`endif
endmodule

// File: rtl/ysyx_25040129_mem_arbiter.sv
// ysyx_25040129_mem_arbiter: IFU/LSU to single memory port arbiter, one outstanding transaction; YSYX_25040129_ARB_RR_EN selects round-robin
module ysyx_25040129_mem_arbiter
    import ysyx_25040129_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    input  logic                ifu_rsp_ready,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    input  logic                lsu_rsp_ready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    output logic                mem_rsp_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                owner,
    output logic [1:0]          state
);
    state_t              state_q, state_d;
    logic                owner_q, last_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wmask_q;
    logic                sel_valid, sel_grant;
    logic                idle, in_rsp, accept, rsp_done;

    ysyx_25040129_arb_sel u_sel (
        .ifu_valid   (ifu_req_valid),
        .lsu_valid   (lsu_req_valid),
        .last_grant  (last_q),
        .grant_valid (sel_valid),
        .grant       (sel_grant)
    );

    assign idle     = rst_n && state_q == ST_IDLE;
    assign in_rsp   = state_q == ST_RSP;
    assign accept   = idle && sel_valid;
    assign rsp_done = in_rsp && mem_rsp_valid && mem_rsp_ready;

    assign ifu_req_ready = accept && sel_grant == OWN_IFU;
    assign lsu_req_ready = accept && sel_grant == OWN_LSU;
    assign mem_req_valid = state_q == ST_REQ;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign mem_rsp_ready = in_rsp && (owner_q == OWN_LSU ? lsu_rsp_ready : ifu_rsp_ready);
    assign ifu_rsp_valid = in_rsp && owner_q == OWN_IFU && mem_rsp_valid;
    assign lsu_rsp_valid = in_rsp && owner_q == OWN_LSU && mem_rsp_valid;
    assign ifu_rdata     = owner_q == OWN_IFU ? mem_rdata : '0;
    assign lsu_rdata     = owner_q == OWN_LSU ? mem_rdata : '0;
    assign owner         = owner_q;
    assign state         = state_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // next state: accept -> issue to memory -> wait for response; stray encodings recover to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = sel_valid ? ST_REQ : ST_IDLE;
            ST_REQ:  state_d = mem_req_ready ? ST_RSP : ST_REQ;
            ST_RSP:  state_d = rsp_done ? ST_IDLE : ST_RSP;
            default: state_d = ST_IDLE;
        endcase
    end

    // capture the granted request (IFU reads carry no write data) and remember the last winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_IFU;
            last_q  <= OWN_LSU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            if (accept) begin
                owner_q <= sel_grant;
                addr_q  <= sel_grant == OWN_LSU ? lsu_addr : ifu_addr;
                wen_q   <= sel_grant == OWN_LSU && lsu_wen;
                wdata_q <= sel_grant == OWN_LSU ? lsu_wdata : '0;
                wmask_q <= sel_grant == OWN_LSU ? lsu_wmask : '0;
            end
            if (rsp_done) last_q <= owner_q;
        end
    end
endmodule

// File: doc/ysyx_25040129_mem_arbiter.md
YSYX_25040129_MEM_ARBITER -- requirements
Module: ysyx_25040129_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of all ports, SHALL apply to every address port.
REQ-002 Parameter DATA_W, 32, data width; wmask width SHALL be DATA_W/8.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 ifu_req_valid in 1 / ifu_req_ready out 1 / ifu_addr in ADDR_W: IFU read request channel.
REQ-006 ifu_rsp_valid out 1 / ifu_rsp_ready in 1 / ifu_rdata out DATA_W: IFU response channel.
REQ-007 lsu_req_valid in 1 / lsu_req_ready out 1 / lsu_addr in ADDR_W / lsu_wen in 1 / lsu_wdata in DATA_W / lsu_wmask in DATA_W/8: LSU request channel.
REQ-008 lsu_rsp_valid out 1 / lsu_rsp_ready in 1 / lsu_rdata out DATA_W: LSU response channel.
REQ-009 mem_req_valid out 1 / mem_req_ready in 1 / mem_addr out ADDR_W / mem_wen out 1 / mem_wdata out DATA_W / mem_wmask out DATA_W/8: downstream memory request.
REQ-010 mem_rsp_valid in 1 / mem_rsp_ready out 1 / mem_rdata in DATA_W: downstream memory response.
REQ-011 owner out 1 (0=IFU, 1=LSU) and state out 2: debug visibility of current grant and FSM state.

Function
REQ-012 FSM SHALL have states IDLE=0, REQ=1, RSP=2; encoding 3 SHALL fall back to IDLE.
REQ-013 IDLE: if any *_req_valid, arbiter SHALL select one master (REQ-024), assert only that master's *_req_ready combinationally in the same cycle, latch its addr/wen/wdata/wmask and owner, and move to REQ.
REQ-014 IFU requests SHALL be latched as wen=0, wdata=0, wmask=0.
REQ-015 *_req_ready SHALL be 0 in every state other than IDLE; no second request is accepted while one is outstanding.
REQ-016 REQ: mem_req_valid=1 with latched fields, stable until mem_req_ready; on mem_req_ready, SHALL move to RSP.
REQ-017 RSP: mem_rsp_ready SHALL equal the owner's *_rsp_ready; owner's *_rsp_valid SHALL equal mem_rsp_valid; non-owner *_rsp_valid SHALL be 0.
REQ-018 *_rdata SHALL carry mem_rdata when that master is owner, else 0.
REQ-019 RSP: on mem_rsp_valid && mem_rsp_ready, SHALL return to IDLE and record owner as last_grant.
REQ-020 Minimum latency: request accepted in cycle N, mem_req_valid in N+1, response earliest N+2 (mem_req_ready high in N+1), next acceptance earliest N+3.
REQ-021 mem_req_valid and mem_rsp_ready SHALL be 0 in IDLE; mem_rsp_ready SHALL be 0 in REQ.
REQ-022 Fields on mem_* request outputs SHALL come only from registers (no combinational path from master inputs).
REQ-023 Master deasserting req_valid in IDLE before grant SHALL not be granted; simultaneous valid SHALL resolve per REQ-024 with exactly one ready.

Reset
REQ-025 On rst_n low, asynchronously: state=IDLE, owner=0, last_grant=LSU, latched fields=0, all valid/ready outputs=0 (except IDLE readys per REQ-013 after release).
REQ-026 Reset mid-transaction SHALL abandon it; no response SHALL be forwarded after reset release.

Configuration
REQ-024 Macro YSYX_25040129_ARB_RR_EN: defined -> round-robin; on simultaneous valid, grant the master other than last_grant (IFU first after reset); undefined -> fixed priority, LSU always wins simultaneous valid; last_grant still tracked but unused.

Structure
REQ-027 Shared package/header SHALL hold state encodings (IDLE/REQ/RSP), owner encodings (OWN_IFU/OWN_LSU) and default widths.
REQ-028 One sub-module ysyx_25040129_arb_sel (2-input grant select from valids, last_grant, macro) is natural; FSM and datapath stay in top.

Verification
REQ-029 IFU alone: ifu_req_valid=1, ifu_addr=0x80000000, mem ready at once, mem_rdata=0x00000413 -> mem_addr=0x80000000, mem_wen=0, ifu_rdata=0x00000413 with ifu_rsp_valid two cycles after accept.
REQ-030 LSU write: lsu_addr=0x80001000, lsu_wdata=0xDEADBEEF, lsu_wmask=0xF, wen=1 -> mem_* carry same values; lsu_rsp_valid on ack; ifu_rsp_valid stays 0.
REQ-031 Both valid every cycle, RR_EN defined -> grants alternate IFU,LSU,IFU,LSU; undefined -> LSU granted continually, IFU starved.
REQ-032 mem_req_ready held 0 for 5 cycles -> mem_req_valid and fields stable 5 cycles, both *_req_ready 0.
REQ-033 Owner rsp_ready=0 while mem_rsp_valid=1 for 3 cycles -> mem_rsp_ready=0, state stays RSP, no return to IDLE.
REQ-034 rst_n pulsed low while in RSP -> state=IDLE, all valid outputs 0 immediately; new IFU request served normally after release.
